// File: rtl/instruction_decode.sv
// ID stage of the 5-stage RV32I pipeline: control decode, register file, hazard
// detection, early beq/bne resolution and the ID/EX pipeline register.
module instruction_decode #(
    parameter bit RESET_REGFILE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_ID_pc,
    input  logic [31:0] IF_ID_inst,
    input  logic        WB_reg_write,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    input  logic        EX_MEM_reg_write,
    input  logic        EX_MEM_mem_read,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_alu_result,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        IF_flush,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] ID_EX_rs1_data,
    output logic [31:0] ID_EX_rs2_data,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [2:0]  ID_EX_funct3,
    output logic        ID_EX_funct7b5,
    output logic        ID_EX_reg_write,
    output logic        ID_EX_mem_read,
    output logic        ID_EX_mem_write,
    output logic        ID_EX_mem_to_reg,
    output logic        ID_EX_alu_src,
    output logic [1:0]  ID_EX_alu_op
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [1:0]  alu_op;
    } id_ex_t;

    id_ex_t      id_ex_d, id_ex_q;
    logic [31:0] regfile_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_load, is_store, is_branch;
    logic        use_rs1, use_rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm;
    logic [31:0] rs1_val, rs2_val, br_a, br_b;
    logic        load_use, branch_stall, stall, br_taken;

    assign opcode = IF_ID_inst[6:0];
    assign rd     = IF_ID_inst[11:7];
    assign funct3 = IF_ID_inst[14:12];
    assign rs1    = IF_ID_inst[19:15];
    assign rs2    = IF_ID_inst[24:20];

    always_comb begin : decode
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_I);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        use_rs1   = is_r | is_i | is_load | is_store | is_branch;
        use_rs2   = is_r | is_store | is_branch;
        imm_i = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
        imm_s = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:25], IF_ID_inst[11:7]};
        imm_b = {{19{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
                 IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};
        imm = '0;
        if (is_i || is_load) imm = imm_i;
        else if (is_store)   imm = imm_s;
        else if (is_branch)  imm = imm_b;
    end

    // Register file reads see a same-cycle writeback (write-before-read).
    always_comb begin : rf_read
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0)
            rs1_val = (WB_reg_write && WB_rd == rs1) ? WB_data : regfile_q[rs1];
        if (rs2 != 5'd0)
            rs2_val = (WB_reg_write && WB_rd == rs2) ? WB_data : regfile_q[rs2];
    end

    always_ff @(posedge clk) begin
        if (reset && RESET_REGFILE) begin
            for (int i = 1; i < 32; i++) regfile_q[i] <= '0;
        end else if (WB_reg_write && WB_rd != 5'd0) begin
            regfile_q[WB_rd] <= WB_data;
        end
    end

    always_comb begin : branch_resolve
        br_a = rs1_val;
        br_b = rs2_val;
        if (EX_MEM_reg_write && !EX_MEM_mem_read && EX_MEM_rd != 5'd0 && EX_MEM_rd == rs1)
            br_a = EX_MEM_alu_result;
        if (EX_MEM_reg_write && !EX_MEM_mem_read && EX_MEM_rd != 5'd0 && EX_MEM_rd == rs2)
            br_b = EX_MEM_alu_result;
        br_taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                3'b000:  br_taken = (br_a == br_b);
                3'b001:  br_taken = (br_a != br_b);
                default: br_taken = 1'b0;
            endcase
        end
    end

    // A branch cannot read a result still in EX, nor a load still in MEM.
    always_comb begin : hazards
        load_use = id_ex_q.mem_read && id_ex_q.rd != 5'd0 &&
                   ((use_rs1 && id_ex_q.rd == rs1) || (use_rs2 && id_ex_q.rd == rs2));
        branch_stall = is_branch &&
                       ((id_ex_q.reg_write && id_ex_q.rd != 5'd0 &&
                         (id_ex_q.rd == rs1 || id_ex_q.rd == rs2)) ||
                        (EX_MEM_mem_read && EX_MEM_rd != 5'd0 &&
                         (EX_MEM_rd == rs1 || EX_MEM_rd == rs2)));
        stall = !reset && (load_use || branch_stall);
    end

    assign pc_write    = !stall;
    assign IF_ID_write = !stall;
    assign pc_src      = !reset && !stall && br_taken;
    assign IF_flush    = pc_src;
    assign pc_branch   = IF_ID_pc + imm_b;

    always_comb begin : id_ex_next
        id_ex_d = '0;
        if (!stall) begin
            id_ex_d.pc         = IF_ID_pc;
            id_ex_d.rs1_data   = rs1_val;
            id_ex_d.rs2_data   = rs2_val;
            id_ex_d.imm        = imm;
            id_ex_d.rs1        = rs1;
            id_ex_d.rs2        = rs2;
            id_ex_d.rd         = rd;
            id_ex_d.funct3     = funct3;
            id_ex_d.funct7b5   = IF_ID_inst[30];
            id_ex_d.reg_write  = (is_r || is_i || is_load) && rd != 5'd0;
            id_ex_d.mem_read   = is_load;
            id_ex_d.mem_write  = is_store;
            id_ex_d.mem_to_reg = is_load;
            id_ex_d.alu_src    = is_i || is_load || is_store;
            if (is_r)           id_ex_d.alu_op = 2'b10;
            else if (is_i)      id_ex_d.alu_op = 2'b11;
            else if (is_branch) id_ex_d.alu_op = 2'b01;
            else                id_ex_d.alu_op = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) id_ex_q <= '0;
        else       id_ex_q <= id_ex_d;
    end

    assign ID_EX_pc         = id_ex_q.pc;
    assign ID_EX_rs1_data   = id_ex_q.rs1_data;
    assign ID_EX_rs2_data   = id_ex_q.rs2_data;
    assign ID_EX_imm        = id_ex_q.imm;
    assign ID_EX_rs1        = id_ex_q.rs1;
    assign ID_EX_rs2        = id_ex_q.rs2;
    assign ID_EX_rd         = id_ex_q.rd;
    assign ID_EX_funct3     = id_ex_q.funct3;
    assign ID_EX_funct7b5   = id_ex_q.funct7b5;
    assign ID_EX_reg_write  = id_ex_q.reg_write;
    assign ID_EX_mem_read   = id_ex_q.mem_read;
    assign ID_EX_mem_write  = id_ex_q.mem_write;
    assign ID_EX_mem_to_reg = id_ex_q.mem_to_reg;
    assign ID_EX_alu_src    = id_ex_q.alu_src;
    assign ID_EX_alu_op     = id_ex_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed pipeline scenarios followed by random
// instruction streams, all checked against an instruction-level reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        WB_reg_write;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        EX_MEM_reg_write, EX_MEM_mem_read;
    logic [4:0]  EX_MEM_rd;
    logic [31:0] EX_MEM_alu_result;
    logic        pc_write, IF_ID_write, pc_src, IF_flush;
    logic [31:0] pc_branch;
    logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write;
    logic        ID_EX_mem_to_reg, ID_EX_alu_src;
    logic [1:0]  ID_EX_alu_op;

    always #5 clk = ~clk;

    instruction_decode #(.RESET_REGFILE(1'b1)) dut (
        .clk(clk), .reset(reset), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .WB_reg_write(WB_reg_write), .WB_rd(WB_rd), .WB_data(WB_data),
        .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_alu_result(EX_MEM_alu_result),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .pc_src(pc_src),
        .pc_branch(pc_branch), .IF_flush(IF_flush),
        .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7b5(ID_EX_funct7b5),
        .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
        .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_alu_op(ID_EX_alu_op)
    );

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7, rw, mr, mw, m2r, as;
        logic [1:0]  aop;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_regs [32];
    exp_t        m_q, m_nxt;
    logic        e_pcw, e_src;
    logic [31:0] e_br;
    logic        s_pcw, s_src, s_flush;
    logic [31:0] s_br;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rf(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (WB_reg_write && WB_rd == r) return WB_data;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r);
        if (EX_MEM_reg_write && !EX_MEM_mem_read && EX_MEM_rd != 5'd0 && EX_MEM_rd == r)
            return EX_MEM_alu_result;
        return rf(r);
    endfunction

    function automatic logic waits_on(input logic [4:0] w, input logic [4:0] r);
        return w != 5'd0 && w == r;
    endfunction

    // Expected behaviour of the current ID cycle, from the instruction's meaning.
    task automatic model_comb();
        logic [6:0]  opc;
        logic [4:0]  a, b, d;
        logic [2:0]  f3;
        logic        isR, isI, isL, isS, isB, u1, u2, st, tk;
        logic [31:0] immB;
        opc = IF_ID_inst[6:0];
        d = IF_ID_inst[11:7]; f3 = IF_ID_inst[14:12];
        a = IF_ID_inst[19:15]; b = IF_ID_inst[24:20];
        isR = opc == 7'h33; isI = opc == 7'h13; isL = opc == 7'h03;
        isS = opc == 7'h23; isB = opc == 7'h63;
        u1 = isR || isI || isL || isS || isB;
        u2 = isR || isS || isB;
        immB = 32'($signed({IF_ID_inst[31], IF_ID_inst[7], IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0}));
        st = (m_q.mr && ((u1 && waits_on(m_q.rd, a)) || (u2 && waits_on(m_q.rd, b)))) ||
             (isB && m_q.rw && (waits_on(m_q.rd, a) || waits_on(m_q.rd, b))) ||
             (isB && EX_MEM_mem_read && (waits_on(EX_MEM_rd, a) || waits_on(EX_MEM_rd, b)));
        st = st && !reset;
        tk = isB && ((f3 == 3'd0 && opnd(a) == opnd(b)) || (f3 == 3'd1 && opnd(a) != opnd(b)));
        e_pcw = !st;
        e_src = !reset && !st && tk;
        e_br  = IF_ID_pc + immB;
        m_nxt = '0;
        if (!reset && !st) begin
            m_nxt.pc = IF_ID_pc; m_nxt.rs1d = rf(a); m_nxt.rs2d = rf(b);
            if (isI || isL) m_nxt.imm = 32'($signed(IF_ID_inst[31:20]));
            else if (isS)   m_nxt.imm = 32'($signed({IF_ID_inst[31:25], IF_ID_inst[11:7]}));
            else if (isB)   m_nxt.imm = immB;
            m_nxt.rs1 = a; m_nxt.rs2 = b; m_nxt.rd = d; m_nxt.f3 = f3; m_nxt.f7 = IF_ID_inst[30];
            m_nxt.rw = (isR || isI || isL) && d != 5'd0;
            m_nxt.mr = isL; m_nxt.mw = isS; m_nxt.m2r = isL; m_nxt.as = isI || isL || isS;
            m_nxt.aop = isR ? 2'd2 : isI ? 2'd3 : isB ? 2'd1 : 2'd0;
        end
    endtask

    // One clock: check ID-stage outputs mid-cycle, then the registered ID/EX.
    task automatic step();
        model_comb();
        @(negedge clk);
        s_pcw = pc_write; s_src = pc_src; s_flush = IF_flush; s_br = pc_branch;
        check("pc_write", 32'(pc_write), 32'(e_pcw));
        check("IF_ID_write", 32'(IF_ID_write), 32'(e_pcw));
        check("pc_src", 32'(pc_src), 32'(e_src));
        check("IF_flush", 32'(IF_flush), 32'(e_src));
        check("pc_branch", pc_branch, e_br);
        @(posedge clk);
        if (reset) begin
            for (int i = 1; i < 32; i++) m_regs[i] = '0;
        end else if (WB_reg_write && WB_rd != 5'd0) begin
            m_regs[WB_rd] = WB_data;
        end
        m_q = m_nxt;
        #1;
        check("ID_EX_pc", ID_EX_pc, m_q.pc);
        check("ID_EX_rs1_data", ID_EX_rs1_data, m_q.rs1d);
        check("ID_EX_rs2_data", ID_EX_rs2_data, m_q.rs2d);
        check("ID_EX_imm", ID_EX_imm, m_q.imm);
        check("ID_EX_rs1", 32'(ID_EX_rs1), 32'(m_q.rs1));
        check("ID_EX_rs2", 32'(ID_EX_rs2), 32'(m_q.rs2));
        check("ID_EX_rd", 32'(ID_EX_rd), 32'(m_q.rd));
        check("ID_EX_funct3", 32'(ID_EX_funct3), 32'(m_q.f3));
        check("ID_EX_funct7b5", 32'(ID_EX_funct7b5), 32'(m_q.f7));
        check("ID_EX_reg_write", 32'(ID_EX_reg_write), 32'(m_q.rw));
        check("ID_EX_mem_read", 32'(ID_EX_mem_read), 32'(m_q.mr));
        check("ID_EX_mem_write", 32'(ID_EX_mem_write), 32'(m_q.mw));
        check("ID_EX_mem_to_reg", 32'(ID_EX_mem_to_reg), 32'(m_q.m2r));
        check("ID_EX_alu_src", 32'(ID_EX_alu_src), 32'(m_q.as));
        check("ID_EX_alu_op", 32'(ID_EX_alu_op), 32'(m_q.aop));
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] b,
                                          input logic [4:0] a, input logic [4:0] d);
        return {f7, b, a, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] off, input logic [4:0] b,
                                            input logic [4:0] a);
        return {off[12], off[10:5], b, a, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    task automatic idle();
        IF_ID_inst = '0; WB_reg_write = 1'b0; WB_rd = '0; WB_data = '0;
        EX_MEM_reg_write = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_rd = '0; EX_MEM_alu_result = '0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    w[6:0] = 7'b0110011;
            2:       w[6:0] = 7'b0010011;
            3:       w[6:0] = 7'b0000011;
            4:       w[6:0] = 7'b0100011;
            5, 6:    begin w[6:0] = 7'b1100011; w[14:12] = 3'($urandom_range(0, 3)); end
            7:       w = '0;
            default: ;
        endcase
        if (w != 32'd0) begin
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_q = '0;
        idle();
        reset = 1'b1; IF_ID_pc = 32'h100;
        @(posedge clk); #1;

        // Reset with busy inputs
        IF_ID_inst = enc_r(7'd0, 5'd3, 5'd2, 5'd1);
        WB_reg_write = 1'b1; WB_rd = 5'd5; WB_data = 32'hDEAD_BEEF;
        EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd2;
        step();
        step();
        check("reset_pc_write", 32'(s_pcw), 32'd1);
        check("reset_pc_src", 32'(s_src), 32'd0);
        reset = 1'b0; idle();

        // Register writes, R-type and I-type decode
        WB_reg_write = 1'b1; WB_rd = 5'd12; WB_data = 32'd5; step();
        WB_rd = 5'd14; WB_data = 32'd7; step();
        idle(); IF_ID_pc = 32'h104; IF_ID_inst = enc_r(7'd0, 5'd14, 5'd12, 5'd8); step();
        check("add_rs1_data", ID_EX_rs1_data, 32'd5);
        check("add_rs2_data", ID_EX_rs2_data, 32'd7);
        check("add_alu_op", 32'(ID_EX_alu_op), 32'd2);
        IF_ID_inst = {12'hFCE, 5'd10, 3'b000, 5'd15, 7'b0010011}; step();
        check("addi_imm", ID_EX_imm, 32'hFFFF_FFCE);
        check("addi_alu_op", 32'(ID_EX_alu_op), 32'd3);

        // Load-use: exactly one stall cycle
        IF_ID_inst = {12'd8, 5'd2, 3'b010, 5'd14, 7'b0000011}; step();
        IF_ID_inst = enc_r(7'd0, 5'd14, 5'd19, 5'd5); step();
        check("loaduse_stall", 32'(s_pcw), 32'd0);
        check("loaduse_bubble", 32'(ID_EX_reg_write), 32'd0);
        WB_reg_write = 1'b1; WB_rd = 5'd14; WB_data = 32'h0000_ABCD; step();
        check("loaduse_resume", 32'(s_pcw), 32'd1);
        check("loaduse_rs2_data", ID_EX_rs2_data, 32'h0000_ABCD);
        idle(); step();

        // beq resolved in ID with EX/MEM forwarding
        IF_ID_pc = 32'h1C; IF_ID_inst = enc_beq(13'd12, 5'd10, 5'd1);
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd10; EX_MEM_alu_result = 32'd0; step();
        check("beq_taken", 32'(s_src), 32'd1);
        check("beq_flush", 32'(s_flush), 32'd1);
        check("beq_target", s_br, 32'h28);
        check("beq_alu_op", 32'(ID_EX_alu_op), 32'd1);
        EX_MEM_alu_result = 32'd1; step();
        check("beq_not_taken", 32'(s_src), 32'd0);

        // Branch waiting on an ALU result in EX, then on a load in MEM
        idle(); IF_ID_inst = enc_r(7'b0100000, 5'd4, 5'd3, 5'd10); step();
        IF_ID_inst = enc_beq(13'd12, 5'd10, 5'd1); step();
        check("br_ex_stall", 32'(s_pcw), 32'd0);
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd10; EX_MEM_alu_result = 32'd0; step();
        check("br_fwd_taken", 32'(s_src), 32'd1);
        EX_MEM_mem_read = 1'b1; step();
        check("br_load_stall", 32'(s_pcw), 32'd0);

        // x0 write ignored; same-cycle writeback bypass
        idle(); WB_reg_write = 1'b1; WB_rd = 5'd0; WB_data = 32'hFFFF_FFFF; step();
        idle(); IF_ID_inst = enc_r(7'd0, 5'd0, 5'd0, 5'd9); step();
        check("x0_reads_zero", ID_EX_rs1_data, 32'd0);
        WB_reg_write = 1'b1; WB_rd = 5'd7; WB_data = 32'h1234;
        IF_ID_inst = enc_r(7'd0, 5'd0, 5'd7, 5'd1); step();
        check("wb_bypass", ID_EX_rs1_data, 32'h1234);

        // Random instruction streams with occasional reset
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            IF_ID_pc = {$urandom, 2'b00} & 32'h0000_FFFC;
            IF_ID_inst = rand_inst();
            WB_reg_write = 1'($urandom_range(0, 1));
            WB_rd = 5'($urandom_range(0, 7)); WB_data = pick_val();
            EX_MEM_reg_write = 1'($urandom_range(0, 1));
            EX_MEM_mem_read = ($urandom_range(0, 3) == 0);
            EX_MEM_rd = 5'($urandom_range(0, 7)); EX_MEM_alu_result = pick_val();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
